// File: rtl/pong_pkg.sv
// Shared definitions for the pong video pipeline: power-pack mode codes,
// the power-up sequencer state encoding, and screen geometry.
package pong_pkg;

  localparam int unsigned SCREEN_W = 1024;
  localparam int unsigned SCREEN_H = 768;

  // Pack mode codes, identical to the ones used by the display block.
  localparam logic [1:0] MODE_SHRINK = 2'b00;
  localparam logic [1:0] MODE_BOOST  = 2'b01;
  localparam logic [1:0] MODE_IDK    = 2'b10;
  localparam logic [1:0] MODE_SHIELD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SPAWN  = 2'b01,
    ST_ARMED  = 2'b10,
    ST_EFFECT = 2'b11
  } pu_state_e;

  // Fold a 10-bit random offset into 0..span-1. Spans of 512..1024 need at
  // most one subtraction because the offset never reaches twice the span.
  function automatic logic [9:0] wrap_span(input logic [9:0] off,
                                           input logic [10:0] span);
    return (11'(off) >= span) ? 10'(11'(off) - span) : off;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Reusable by any block needing a cheap pseudo-random source.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Shift every cycle; reload the seed on reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (reset) q <= seed;
    else       q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/powerup_ctrl.sv
// Power-up pack sequencer: spawns the pack at pseudo-random coordinates,
// detects the ball eating it once per frame, and times the resulting effect
// for the paddle that last hit the ball.
module powerup_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SPAWN_DELAY   = 300,
  parameter int unsigned EFFECT_FRAMES = 600,
  parameter int unsigned PACK_W        = 20,
  parameter int unsigned PACK_H        = 20,
  parameter int unsigned BALL_SIZE     = 16,
  parameter int unsigned X_MIN         = 64,
  parameter int unsigned X_SPAN        = 896,
  parameter int unsigned Y_MIN         = 32,
  parameter int unsigned Y_SPAN        = 700,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic [10:0] ball_x,
  input  logic [9:0]  ball_y,
  input  logic        last_hit,
  input  logic [10:0] pack_x,
  input  logic [9:0]  pack_y,
  input  logic [1:0]  pack_mode,
  output logic        spawn,
  output logic        eaten,
  output logic [10:0] randx,
  output logic [9:0]  randy,
  output logic        shield_active,
  output logic        boost_active,
  output logic        shrink_active,
  output logic        effect_owner,
  output logic [15:0] frames_left
);

  // A zero-length countdown is treated as a single frame.
  localparam logic [15:0] EFF_LOAD   = (EFFECT_FRAMES == 0) ? 16'd1 : 16'(EFFECT_FRAMES);
  localparam logic [15:0] DELAY_LOAD = (SPAWN_DELAY   == 0) ? 16'd1 : 16'(SPAWN_DELAY);

  pu_state_e   state_q, state_d;
  logic        vsync_q;
  logic        spawn_q, spawn_d;
  logic        eaten_q, eaten_d;
  logic [10:0] randx_q, randx_d;
  logic [9:0]  randy_q, randy_d;
  logic        shield_q, shield_d;
  logic        boost_q, boost_d;
  logic        shrink_q, shrink_d;
  logic        owner_q, owner_d;
  logic [15:0] frames_q, frames_d;

  logic [15:0] lfsr;
  logic        tick;
  logic        hit;
  logic [10:0] cand_x;
  logic [9:0]  cand_y;
  logic [11:0] bx, px, by, py;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr)
  );

  assign tick   = vsync & ~vsync_q;
  assign cand_x = 11'(X_MIN) + {1'b0, wrap_span(lfsr[9:0], 11'(X_SPAN))};
  assign cand_y = 10'(Y_MIN) + wrap_span(lfsr[15:6], 11'(Y_SPAN));

  // Box overlap in 12 bits so edge sums near the screen limit cannot wrap.
  assign bx  = {1'b0, ball_x};
  assign px  = {1'b0, pack_x};
  assign by  = {2'b00, ball_y};
  assign py  = {2'b00, pack_y};
  assign hit = (bx < px + 12'(PACK_W))    && (px < bx + 12'(BALL_SIZE)) &&
               (by < py + 12'(PACK_H))    && (py < by + 12'(BALL_SIZE));

  // Next-state and registered-output logic for the spawn/armed/effect cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d  = state_q;
    spawn_d  = spawn_q;
    eaten_d  = eaten_q;
    randx_d  = randx_q;
    randy_d  = randy_q;
    shield_d = shield_q;
    boost_d  = boost_q;
    shrink_d = shrink_q;
    owner_d  = owner_q;
    frames_d = frames_q;

    unique case (state_q)
      ST_ARMED: begin
        if (tick && hit) begin
          eaten_d  = 1'b1;
          owner_d  = last_hit;
          shield_d = (pack_mode == MODE_SHIELD);
          boost_d  = (pack_mode == MODE_BOOST);
          shrink_d = (pack_mode == MODE_SHRINK);
          frames_d = EFF_LOAD;
          state_d  = ST_EFFECT;
        end
      end
      ST_EFFECT: begin
        if (tick) begin
          if (frames_q <= 16'd1) begin
            shield_d = 1'b0;
            boost_d  = 1'b0;
            shrink_d = 1'b0;
            frames_d = DELAY_LOAD;
            state_d  = ST_IDLE;
          end else begin
            frames_d = frames_q - 16'd1;
          end
        end
      end
      ST_IDLE: begin
        if (tick) begin
          if (frames_q <= 16'd1) begin
            randx_d  = cand_x;
            randy_d  = cand_y;
            spawn_d  = 1'b1;
            eaten_d  = 1'b0;
            frames_d = 16'd0;
            state_d  = ST_SPAWN;
          end else begin
            frames_d = frames_q - 16'd1;
          end
        end
      end
      ST_SPAWN: begin
        spawn_d = 1'b0;
        state_d = ST_ARMED;
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // State and output registers; reset wins over a coincident frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_ARMED;
      vsync_q  <= 1'b0;
      spawn_q  <= 1'b0;
      eaten_q  <= 1'b0;
      randx_q  <= 11'(X_MIN);
      randy_q  <= 10'(Y_MIN);
      shield_q <= 1'b0;
      boost_q  <= 1'b0;
      shrink_q <= 1'b0;
      owner_q  <= 1'b0;
      frames_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= vsync;
      spawn_q  <= spawn_d;
      eaten_q  <= eaten_d;
      randx_q  <= randx_d;
      randy_q  <= randy_d;
      shield_q <= shield_d;
      boost_q  <= boost_d;
      shrink_q <= shrink_d;
      owner_q  <= owner_d;
      frames_q <= frames_d;
    end
  end

  assign spawn         = spawn_q;
  assign eaten         = eaten_q;
  assign randx         = randx_q;
  assign randy         = randy_q;
  assign shield_active = shield_q;
  assign boost_active  = boost_q;
  assign shrink_active = shrink_q;
  assign effect_owner  = owner_q;
  assign frames_left   = frames_q;

endmodule

// File: tb/tb_powerup_ctrl.sv
// Scoreboard bench for powerup_ctrl: stimulus pushes the expected output
// snapshot for every output change it causes; a monitor pops and compares
// whenever the registered outputs change.
module tb_powerup_ctrl;
  import pong_pkg::*;

  localparam int SD = 3;
  localparam int EF = 4;

  typedef struct packed {
    logic        spawn;
    logic        eaten;
    logic [10:0] randx;
    logic [9:0]  randy;
    logic        shield;
    logic        boost;
    logic        shrink;
    logic        owner;
    logic [15:0] fl;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic [10:0] ball_x = 11'd100;
  logic [9:0]  ball_y = 10'd100;
  logic        last_hit = 1'b1;
  logic [10:0] pack_x = 11'd116;
  logic [9:0]  pack_y = 10'd100;
  logic [1:0]  pack_mode = 2'b11;
  logic        spawn, eaten, shield_active, boost_active, shrink_active, effect_owner;
  logic [10:0] randx;
  logic [9:0]  randy;
  logic [15:0] frames_left;

  int n_cmp  = 0;
  int n_fail = 0;

  snap_t e;
  snap_t exp_q[$];
  string nm_q[$];
  logic [15:0] model;

  always #5 clk = ~clk;

  powerup_ctrl #(.SPAWN_DELAY(SD), .EFFECT_FRAMES(EF)) dut (
    .clk           (clk),
    .reset         (reset),
    .vsync         (vsync),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .last_hit      (last_hit),
    .pack_x        (pack_x),
    .pack_y        (pack_y),
    .pack_mode     (pack_mode),
    .spawn         (spawn),
    .eaten         (eaten),
    .randx         (randx),
    .randy         (randy),
    .shield_active (shield_active),
    .boost_active  (boost_active),
    .shrink_active (shrink_active),
    .effect_owner  (effect_owner),
    .frames_left   (frames_left)
  );

  // Reference LFSR running in lockstep with the design's generator.
  always @(posedge clk)
    model <= reset ? 16'hACE1 : {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};

  function automatic logic [10:0] exp_rx(input logic [15:0] m);
    int off = int'(m[9:0]);
    if (off >= 896) off -= 896;
    return 11'(64 + off);
  endfunction

  function automatic logic [9:0] exp_ry(input logic [15:0] m);
    int off = int'(m[15:6]);
    if (off >= 700) off -= 700;
    return 10'(32 + off);
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.spawn  = spawn;
    s.eaten  = eaten;
    s.randx  = randx;
    s.randy  = randy;
    s.shield = shield_active;
    s.boost  = boost_active;
    s.shrink = shrink_active;
    s.owner  = effect_owner;
    s.fl     = frames_left;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic expect_evt(input string name);
    exp_q.push_back(e);
    nm_q.push_back(name);
  endtask

  function automatic snap_t reset_snap();
    snap_t s;
    s = '0;
    s.randx = 11'd64;
    s.randy = 10'd32;
    return s;
  endfunction

  // One frame: vsync high for one cycle; returns right after the tick edge.
  task automatic frame_tick();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
  endtask

  // Collision tick followed by the effect countdown and the spawn gap.
  task automatic hit_and_count(input string name, input logic [1:0] mode, input logic who);
    pack_mode = mode;
    last_hit  = who;
    e.eaten   = 1'b1;
    e.owner   = who;
    e.shield  = (mode == 2'b11);
    e.boost   = (mode == 2'b01);
    e.shrink  = (mode == 2'b00);
    e.fl      = 16'd4;
    expect_evt(name);
    frame_tick();
    check({name, "_latency_eaten"}, 64'(eaten), 64'd1);
    for (int k = 3; k >= 1; k--) begin
      e.fl = 16'(k);
      expect_evt({name, "_effect_dec"});
      frame_tick();
    end
    e.shield = 1'b0;
    e.boost  = 1'b0;
    e.shrink = 1'b0;
    e.fl     = 16'd3;
    expect_evt({name, "_effect_end"});
    frame_tick();
    for (int k = 2; k >= 1; k--) begin
      e.fl = 16'(k);
      expect_evt({name, "_idle_dec"});
      frame_tick();
    end
  endtask

  // Spawn tick, optionally delayed until the LFSR low bits equal tgt.
  task automatic spawn_tick(input string name, input bit aligned,
                            input logic [9:0] tgt, input logic [10:0] want_x);
    int waited = 0;
    @(negedge clk);
    while (aligned && model[9:0] != tgt && waited < 30000) begin
      @(negedge clk);
      waited++;
    end
    if (aligned && model[9:0] != tgt) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_align: lfsr low bits %0d never reached %0d", name, model[9:0], tgt);
    end
    e.spawn = 1'b1;
    e.eaten = 1'b0;
    e.fl    = 16'd0;
    e.randx = aligned ? want_x : exp_rx(model);
    e.randy = exp_ry(model);
    expect_evt(name);
    e.spawn = 1'b0;
    expect_evt({name, "_end"});
    vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    check({name, "_pulse"}, 64'({spawn, eaten}), 64'(2'b10));
    check({name, "_x_range"}, 64'(randx >= 11'd64 && randx <= 11'd959), 64'd1);
    check({name, "_y_range"}, 64'(randy >= 10'd32 && randy <= 10'd731), 64'd1);
  endtask

  // Monitor: every change of the registered outputs consumes one expectation.
  initial begin
    snap_t prev, cur, w;
    string nm;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = snap();
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: got %h want no change", cur);
        end else begin
          w  = exp_q.pop_front();
          nm = nm_q.pop_front();
          check(nm, {21'd0, cur}, {21'd0, w});
        end
        prev = cur;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    e = reset_snap();
    expect_evt("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("lfsr_seed", 64'(dut.u_lfsr.q), 64'h0000_0000_0000_ACE1);
    check("state_after_reset", 64'(dut.state_q), 64'(ST_ARMED));

    // Ball right edge touches pack left edge: no overlap.
    repeat (5) frame_tick();
    check("near_miss_eaten", 64'(eaten), 64'd0);

    pack_x = 11'd110;
    pack_y = 10'd105;
    hit_and_count("shield", 2'b11, 1'b1);
    spawn_tick("spawn_1000", 1'b1, 10'd1000, 11'd168);

    hit_and_count("mode10", 2'b10, 1'b0);
    spawn_tick("spawn_895", 1'b1, 10'd895, 11'd959);

    hit_and_count("shrink", 2'b00, 1'b1);
    spawn_tick("spawn_free", 1'b0, 10'd0, 11'd0);

    // Boost effect interrupted by reset that coincides with a frame tick.
    pack_mode = 2'b01;
    last_hit  = 1'b0;
    e.eaten = 1'b1;
    e.owner = 1'b0;
    e.boost = 1'b1;
    e.fl    = 16'd4;
    expect_evt("boost");
    frame_tick();
    e.fl = 16'd3;
    expect_evt("boost_dec");
    frame_tick();
    check("boost_on", 64'(boost_active), 64'd1);
    e = reset_snap();
    expect_evt("reset_mid_effect");
    @(negedge clk);
    reset = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    check("reset_mid_boost", 64'(boost_active), 64'd0);
    check("reset_mid_state", 64'(dut.state_q), 64'(ST_ARMED));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/powerup_ctrl.md
# powerup_ctrl

Sequencer for the power-up pack. It generates pseudo-random spawn coordinates and the `spawn`/`eaten` controls consumed by the power-pack display block. It detects ball/pack collision once per video frame and runs the timed power-up effect (shield, boost, shrink) for the paddle that last hit the ball. It sits directly upstream of the power-pack block and downstream of the ball/paddle logic, in the 1024×768 video clock domain.

## Interface
- `SPAWN_DELAY`, default 300: frames from effect end to next spawn.
- `EFFECT_FRAMES`, default 600: effect duration in frames.
- `PACK_W`, `PACK_H`, default 20 / 20: pack size in pixels; must match the display block.
- `BALL_SIZE`, default 16: ball square size in pixels.
- `X_MIN`, `X_SPAN`, default 64 / 896: spawn x range is `X_MIN .. X_MIN+X_SPAN-1`; `X_SPAN` must be in 512..1024.
- `Y_MIN`, `Y_SPAN`, default 32 / 700: spawn y range, same rule as x.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high. Clock is `clk`.
- `vsync` in 1: frame sync, active-high.
- `ball_x` in 11: ball left edge.
- `ball_y` in 10: ball top edge.
- `last_hit` in 1: paddle that last touched the ball (0 = left, 1 = right).
- `pack_x` in 11, `pack_y` in 10: pack position, fed back from the display block.
- `pack_mode` in 2: pack mode, fed back from the display block.
- `spawn` out 1: one-cycle spawn pulse.
- `eaten` out 1: level; pack consumed.
- `randx` out 11, `randy` out 10: spawn coordinates.
- `shield_active`, `boost_active`, `shrink_active` out 1 each: effect flags.
- `effect_owner` out 1: paddle receiving the effect.
- `frames_left` out 16: remaining frames in the current countdown.

## Operation
- **LFSR.** 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1. It shifts every cycle and reloads `SEED` on reset.
- **Position mapping.**
  - x_off = lfsr[9:0]; if x_off ≥ X_SPAN then x_off − X_SPAN.
  - y_off = lfsr[15:6], reduced by Y_SPAN the same way.
  - Candidate coordinates are X_MIN+x_off and Y_MIN+y_off.
- **Frame tick.** A frame tick is a one-cycle pulse on the rising edge of `vsync`, detected with a registered copy of `vsync`.
- **Collision.** True when the boxes overlap: ball_x < pack_x+PACK_W, pack_x < ball_x+BALL_SIZE, and the same test on y. Compute in 12 bits so nothing wraps.
- **States:** IDLE, SPAWN, ARMED, EFFECT.
- **After reset:** state ARMED, because the display block places the pack at reset. Reset values:
  - `randx`=X_MIN, `randy`=Y_MIN.
  - `spawn`=0, `eaten`=0.
  - All effect flags 0, `effect_owner`=0, `frames_left`=0.
- **ARMED:** on a frame tick with collision:
  - `eaten`<=1 and `effect_owner`<=`last_hit`.
  - Set the flag for `pack_mode`: 2'b11 shield, 2'b01 boost, 2'b00 shrink. 2'b10 sets no flag but is still timed.
  - `frames_left`<=EFFECT_FRAMES, go to EFFECT.
- **EFFECT:** each frame tick decrements `frames_left`. On a tick while it is 1:
  - Clear all flags and set `frames_left`<=SPAWN_DELAY, go to IDLE.
  - `eaten` stays 1.
- **IDLE:** each frame tick decrements `frames_left`. On a tick while it is 1:
  - `randx`/`randy`<=candidate, `spawn`<=1, `eaten`<=0, all on the same edge.
  - Go to SPAWN.
- **SPAWN:** `spawn`<=0, go to ARMED. No other action.
- **Zero parameters:** EFFECT_FRAMES=0 or SPAWN_DELAY=0 behave as 1.

## Timing
- All outputs are registered.
- `spawn`, `eaten`=0 and the new `randx`/`randy` become visible in the same cycle, so the display block sees `spawn && !eaten` together with stable coordinates.
- `spawn` is exactly one cycle wide.
- Collision-to-`eaten` latency: 1 cycle after the frame-tick cycle. Collision is sampled only on frame ticks.
- Effect length is exactly EFFECT_FRAMES ticks from entering EFFECT. The spawn gap is SPAWN_DELAY ticks.
- **Reset mid-effect:** flags clear in the cycle after reset is sampled, and the state returns to ARMED.
- **Reset priority:** reset overrides everything, including a simultaneous frame tick.
- Hold `reset` ≥ 2 cycles so the display block latches the reset coordinates.
- A frame tick in SPAWN is ignored.
- Collision in IDLE or EFFECT is ignored.

## Structure
- Shared package `pong_pkg` holds:
  - Mode constants: MODE_SHRINK=2'b00, MODE_BOOST=2'b01, MODE_IDK=2'b10, MODE_SHIELD=2'b11. The display block uses the same values.
  - The state encoding for the four states.
  - Screen dimensions 1024/768.
- Sub-module `lfsr16`:
  - Ports: clk, reset, seed, q[15:0].
  - Free-running; reusable by other random sources.

## Test plan
Use SPAWN_DELAY=3, EFFECT_FRAMES=4.
- **Reset:** hold reset 3 cycles → `randx`=64, `randy`=32, `spawn`=0, `eaten`=0, flags 0, state ARMED; LFSR equals 16'hACE1 on the first cycle after reset.
- **Shield collision:** ball (100,100), pack (110,105), mode 2'b11, `last_hit`=1, one vsync rise → `eaten`=1, `shield_active`=1, `effect_owner`=1, `frames_left`=4 one cycle after the tick.
- **Near miss:** ball (100,100), pack (116,100) → no collision over 5 frames; `eaten` stays 0.
- **Full cycle:**
  - After 4 further ticks, flags clear and `frames_left`=3.
  - After 3 more ticks, `spawn` pulses for one cycle with `eaten`=0.
  - `randx` lies in 64..959 and `randy` in 32..731, each matching a reference model of the LFSR.
- **Reduction boundary:** force lfsr[9:0]=1000 → `randx`=64+104=168; lfsr[9:0]=895 → `randx`=959.
- **Mode 2'b10:** collision with pack_mode 2'b10 → no flag set, effect still lasts 4 ticks.
- **Reset mid-effect:** reset during EFFECT with `boost_active`=1 → flags 0 and state ARMED on the next cycle.
